// File: rtl/sr_latch_sequencer_pkg.sv
// Shared types and helpers for the gated SR latch sequencer.
package sr_seq_pkg;

  // Sequencer states: one full operation walks IDLE -> SETUP -> PULSE -> HOLD -> CHECK.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    CHECK = 3'd4
  } state_t;

  // Operation code. OP_RST is the reset value of both op and last-grant.
  typedef enum logic {
    OP_RST = 1'b0,
    OP_SET = 1'b1
  } op_t;

  // Width of the phase down-counter: large enough to hold the longest phase length.
  function automatic int cnt_w(input int setup_cyc, input int pulse_cyc, input int hold_cyc);
    int m;
    m = setup_cyc;
    if (pulse_cyc > m) begin
      m = pulse_cyc;
    end else begin
      m = m;
    end
    if (hold_cyc > m) begin
      m = hold_cyc;
    end else begin
      m = m;
    end
    return $clog2(m + 32'sd1);
  endfunction

  // Value Q must read back after an operation completes.
  function automatic logic op_expect_q(input op_t op);
    return (op == OP_SET) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/sr_latch_sequencer_gated_sr_latch_gl.sv
// Gated SR latch: AND gates qualify S and R with the enable, a level-sensitive
// storage node holds Q, and NOT-Q is produced by the classic NOR stage.
// The sequencer never presents S=R=1 while enabled, so the forbidden state
// of the cross-coupled form cannot occur here.
module gated_sr_latch_gl (
  input  logic s,
  input  logic r,
  input  logic e,
  output logic q,
  output logic notq
);

  logic s_g_s;
  logic r_g_s;
  logic q_st_s;

  and u_and_s (s_g_s, s, e);
  and u_and_r (r_g_s, r, e);

  // Storage node: transparent while a gated S or R is active, holds otherwise.
  always_latch begin
    if (s_g_s | r_g_s) begin
      q_st_s <= s_g_s;
    end
  end

  nor u_nor_nq (notq, q_st_s, s_g_s);

  assign q = q_st_s;

endmodule

// File: rtl/sr_latch_sequencer.sv
// Arbitrates set/reset requests onto one gated SR latch, drives the
// setup / enable-pulse / hold sequence and verifies Q after each operation.
module sr_latch_sequencer
  import sr_seq_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4,
  parameter int HOLD_CYC  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic rst_req,
  output logic set_ack,
  output logic rst_ack,
  output logic busy,
  output logic q,
  output logic err
);

  localparam int CW = cnt_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC);

  state_t          state_q, state_d;
  op_t             op_q, op_d;
  op_t             last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            set_ack_q, set_ack_d;
  logic            rst_ack_q, rst_ack_d;
  logic            err_q, err_d;
  logic            lat_s_q, lat_s_d;
  logic            lat_r_q, lat_r_d;
  logic            lat_e_q, lat_e_d;
  logic            q_q, q_d;
  logic            drive_s;
  logic            lat_q_s;
  logic            lat_notq_unused_s;

  gated_sr_latch_gl u_latch (
    .s    (lat_s_q),
    .r    (lat_r_q),
    .e    (lat_e_q),
    .q    (lat_q_s),
    .notq (lat_notq_unused_s)
  );

  // Next-state logic: arbitration in IDLE, phase counting, and readback check.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        // On a tie the requester not served last wins; last resets to RST so set wins first.
        if (set_req && (!rst_req || (last_q == OP_RST))) begin
          op_d    = OP_SET;
          last_d  = OP_SET;
          cnt_d   = SETUP_LD;
          state_d = SETUP;
        end else if (rst_req) begin
          op_d    = OP_RST;
          last_d  = OP_RST;
          cnt_d   = SETUP_LD;
          state_d = SETUP;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_ONE) begin
          cnt_d   = PULSE_LD;
          state_d = PULSE;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      PULSE: begin
        if (cnt_q == CNT_ONE) begin
          cnt_d   = HOLD_LD;
          state_d = HOLD;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_ONE) begin
          cnt_d   = CNT_ZERO;
          state_d = CHECK;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      CHECK: begin
        // q_q was captured after the hold phase, so it reflects the settled latch.
        if (q_q != op_expect_q(op_q)) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        state_d = IDLE;
      end
      default: begin
        cnt_d   = CNT_ZERO;
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop aligned with its state.
  always_comb begin
    drive_s   = (state_d == SETUP) || (state_d == PULSE) || (state_d == HOLD);
    lat_s_d   = drive_s && (op_d == OP_SET);
    lat_r_d   = drive_s && (op_d == OP_RST);
    lat_e_d   = (state_d == PULSE);
    busy_d    = (state_d != IDLE);
    set_ack_d = (state_d == CHECK) && (op_d == OP_SET);
    rst_ack_d = (state_d == CHECK) && (op_d == OP_RST);
    q_d       = lat_q_s;
  end

  // Sequencer state and registered outputs; reset forces the latch clear (R=1, E=1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_RST;
      last_q    <= OP_RST;
      cnt_q     <= CNT_ZERO;
      busy_q    <= 1'b0;
      set_ack_q <= 1'b0;
      rst_ack_q <= 1'b0;
      err_q     <= 1'b0;
      lat_s_q   <= 1'b0;
      lat_r_q   <= 1'b1;
      lat_e_q   <= 1'b1;
      q_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      set_ack_q <= set_ack_d;
      rst_ack_q <= rst_ack_d;
      err_q     <= err_d;
      lat_s_q   <= lat_s_d;
      lat_r_q   <= lat_r_d;
      lat_e_q   <= lat_e_d;
      q_q       <= q_d;
    end
  end

  assign set_ack = set_ack_q;
  assign rst_ack = rst_ack_q;
  assign busy    = busy_q;
  assign q       = q_q;
  assign err     = err_q;

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Bench for sr_latch_sequencer: a default-timing instance (2/4/2) and a
// minimum-timing instance (1/1/1), checked every cycle against an
// operation-level reference model, plus a vector table and directed sequences.
module tb_sr_latch_sequencer;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst     = 2'b11;
  logic [1:0] set_req = 2'b00;
  logic [1:0] rst_req = 2'b00;
  logic [1:0] set_ack, rst_ack, busy, q, err;

  int vectors = 0;
  int miscompares = 0;

  // Phase lengths per instance: [0] = defaults, [1] = minimum.
  int s_c[2] = '{2, 1};
  int p_c[2] = '{4, 1};
  int h_c[2] = '{2, 1};

  // Reference model state. ph counts cycles since grant (0 = idle,
  // 1..S+P+H = driving the latch, S+P+H+1 = the check/ack cycle).
  int ph[2]      = '{0, 0};
  bit op_s[2]    = '{0, 0};
  bit last_s[2]  = '{0, 0};
  bit err_m[2]   = '{0, 0};
  bit latch_m[2] = '{0, 0};
  bit q_m[2]     = '{0, 0};
  bit stuck[2]   = '{0, 0};
  bit frc[2]     = '{1, 1};

  sr_latch_sequencer #(.SETUP_CYC(2), .PULSE_CYC(4), .HOLD_CYC(2)) dut_a (
    .clk(clk), .rst(rst[0]), .set_req(set_req[0]), .rst_req(rst_req[0]),
    .set_ack(set_ack[0]), .rst_ack(rst_ack[0]), .busy(busy[0]), .q(q[0]), .err(err[0])
  );

  sr_latch_sequencer #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) dut_b (
    .clk(clk), .rst(rst[1]), .set_req(set_req[1]), .rst_req(rst_req[1]),
    .set_ack(set_ack[1]), .rst_ack(rst_ack[1]), .busy(busy[1]), .q(q[1]), .err(err[1])
  );

  function automatic bit get_ls(input int i);
    return (i == 0) ? dut_a.lat_s_q : dut_b.lat_s_q;
  endfunction
  function automatic bit get_lr(input int i);
    return (i == 0) ? dut_a.lat_r_q : dut_b.lat_r_q;
  endfunction
  function automatic bit get_le(input int i);
    return (i == 0) ? dut_a.lat_e_q : dut_b.lat_e_q;
  endfunction

  task automatic cmp(input string name, input int i, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, i, act, exp, $time);
    end
  endtask

  // Model advance at a clock edge, using the request levels held across that edge.
  task automatic model_step(input int i);
    int t;
    bit q_old;
    t = s_c[i] + p_c[i] + h_c[i];
    if (rst[i]) begin
      ph[i] = 0; op_s[i] = 0; last_s[i] = 0; err_m[i] = 0;
      latch_m[i] = 0; q_m[i] = 0; frc[i] = 1;
    end else begin
      frc[i] = 0;
      q_old = q_m[i];
      q_m[i] = latch_m[i];
      if (ph[i] == 0) begin
        if (set_req[i] && (!rst_req[i] || !last_s[i])) begin
          op_s[i] = 1; last_s[i] = 1; ph[i] = 1;
        end else if (rst_req[i]) begin
          op_s[i] = 0; last_s[i] = 0; ph[i] = 1;
        end
      end else if (ph[i] <= t) begin
        ph[i]++;
      end else begin
        if (q_old != op_s[i]) err_m[i] = 1;
        ph[i] = 0;
      end
      if (ph[i] > s_c[i] && ph[i] <= s_c[i] + p_c[i] && !stuck[i]) latch_m[i] = op_s[i];
    end
  endtask

  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
  end

  // Per-cycle comparison of every output and the latch drive against the model.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      logic [7:0] exp_v, act_v;
      int t;
      bit act_ph;
      t = s_c[i] + p_c[i] + h_c[i];
      act_ph = (ph[i] >= 1) && (ph[i] <= t);
      if (rst[i] || frc[i]) begin
        exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, rst[i] ? 1'b0 : err_m[i]};
      end else begin
        exp_v = {ph[i] != 0, (ph[i] == t + 1) && op_s[i], (ph[i] == t + 1) && !op_s[i],
                 act_ph && op_s[i], act_ph && !op_s[i],
                 (ph[i] > s_c[i]) && (ph[i] <= s_c[i] + p_c[i]), q_m[i], err_m[i]};
      end
      act_v = {busy[i], set_ack[i], rst_ack[i], get_ls(i), get_lr(i), get_le(i), q[i], err[i]};
      cmp("cycle{busy,sack,rack,s,r,e,q,err}", i, act_v, exp_v);
      cmp("s_and_r_exclusive", i, get_ls(i) & get_lr(i), 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_all();
    rst = 2'b11; set_req = 2'b00; rst_req = 2'b00;
    step(); step();
    rst = 2'b00;
    step(); step();
    for (int i = 0; i < 2; i++) begin
      cmp("q_after_reset", i, q[i], 0);
      cmp("err_after_reset", i, err[i], 0);
    end
  endtask

  // One operation from IDLE: drive requests, wait (bounded) for the ack, check it, release.
  task automatic run_op(input int i, input bit s, input bit r, input bit exp_set,
                        input bit exp_q, input string tag);
    int n, pulses;
    bit got;
    set_req[i] = s; rst_req[i] = r;
    n = 0; pulses = 0; got = 0;
    while (!got && n < 40) begin
      step();
      n++;
      if (get_le(i)) pulses++;
      if (set_ack[i] || rst_ack[i]) got = 1;
    end
    cmp({tag, "_ack_seen"}, i, got, 1);
    cmp({tag, "_latency"}, i, n, s_c[i] + p_c[i] + h_c[i] + 1);
    cmp({tag, "_set_ack"}, i, set_ack[i], exp_set);
    cmp({tag, "_rst_ack"}, i, rst_ack[i], !exp_set);
    cmp({tag, "_pulse_len"}, i, pulses, p_c[i]);
    cmp({tag, "_q"}, i, q[i], exp_q);
    set_req[i] = 0; rst_req[i] = 0;
    step();
  endtask

  // Both requesters stay high; each drops on its ack and re-raises one cycle later.
  task automatic alt_seq(input int i);
    int n;
    bit got;
    set_req[i] = 1; rst_req[i] = 1;
    for (int k = 0; k < 4; k++) begin
      n = 0; got = 0;
      while (!got && n < 40) begin
        step();
        n++;
        if (set_ack[i] || rst_ack[i]) got = 1;
      end
      cmp("alt_ack_seen", i, got, 1);
      cmp("alt_latency", i, n, s_c[i] + p_c[i] + h_c[i] + 1);
      cmp("alt_grant_is_set", i, set_ack[i], (k % 2 == 0) ? 1 : 0);
      if (set_ack[i]) set_req[i] = 0; else rst_req[i] = 0;
      step();
      set_req[i] = 1; rst_req[i] = 1;
    end
    set_req[i] = 0; rst_req[i] = 0;
    step(); step(); step();
  endtask

  typedef struct {
    bit s;
    bit r;
    bit exp_set;
    bit exp_q;
  } vec_t;

  vec_t table_v[6];

  initial begin
    int rst_hold[2];
    table_v[0] = '{s: 1, r: 0, exp_set: 1, exp_q: 1};
    table_v[1] = '{s: 0, r: 1, exp_set: 0, exp_q: 0};
    table_v[2] = '{s: 1, r: 1, exp_set: 1, exp_q: 1};
    table_v[3] = '{s: 1, r: 1, exp_set: 0, exp_q: 0};
    table_v[4] = '{s: 1, r: 1, exp_set: 1, exp_q: 1};
    table_v[5] = '{s: 0, r: 1, exp_set: 0, exp_q: 0};

    reset_all();
    for (int i = 0; i < 2; i++) cmp("busy_idle_after_reset", i, busy[i], 0);

    for (int v = 0; v < 6; v++) begin
      fork
        run_op(0, table_v[v].s, table_v[v].r, table_v[v].exp_set, table_v[v].exp_q, "table");
        run_op(1, table_v[v].s, table_v[v].r, table_v[v].exp_set, table_v[v].exp_q, "table");
      join
    end

    // Tie from reset: set first, then strict alternation.
    reset_all();
    fork
      alt_seq(0);
      alt_seq(1);
    join

    // Reset in the middle of the enable pulse on the default instance.
    set_req[0] = 1;
    step(); step(); step();
    cmp("abort_in_pulse", 0, get_le(0), 1);
    rst[0] = 1;
    #1;
    cmp("abort_busy", 0, busy[0], 0);
    cmp("abort_no_ack", 0, set_ack[0] | rst_ack[0], 0);
    set_req[0] = 0;
    step(); step();
    rst[0] = 0;
    step(); step();
    cmp("abort_q_clear", 0, q[0], 0);
    run_op(0, 1, 0, 1, 1, "post_abort");
    run_op(0, 0, 1, 0, 0, "pre_stuck");

    // Latch output stuck at 0: ack still issued, err sticky until rst.
    force dut_a.lat_q_s = 1'b0;
    stuck[0] = 1; latch_m[0] = 0;
    run_op(0, 1, 0, 1, 0, "stuck_set");
    cmp("stuck_err_set", 0, err[0], 1);
    run_op(0, 0, 1, 0, 0, "stuck_rst");
    release dut_a.lat_q_s;
    stuck[0] = 0;
    run_op(0, 1, 0, 1, 1, "good_set");
    cmp("err_sticky_1", 0, err[0], 1);
    run_op(0, 0, 1, 0, 0, "good_rst");
    cmp("err_sticky_2", 0, err[0], 1);
    reset_all();
    cmp("err_cleared", 0, err[0], 0);

    // Randomised traffic with occasional resets; the per-cycle model check does the work.
    rst_hold[0] = 0; rst_hold[1] = 0;
    for (int c = 0; c < 1500; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (set_ack[i]) set_req[i] = 0;
        else if (!set_req[i] && ($urandom % 4 == 0)) set_req[i] = 1;
        else if (set_req[i] && ($urandom % 40 == 0)) set_req[i] = 0;
        if (rst_ack[i]) rst_req[i] = 0;
        else if (!rst_req[i] && ($urandom % 4 == 0)) rst_req[i] = 1;
        else if (rst_req[i] && ($urandom % 40 == 0)) rst_req[i] = 0;
        if (rst_hold[i] > 0) begin
          rst_hold[i]--;
          if (rst_hold[i] == 0) rst[i] = 0;
        end else if ($urandom % 250 == 0) begin
          rst[i] = 1;
          rst_hold[i] = 2;
        end
      end
    end
    set_req = 2'b00; rst_req = 2'b00; rst = 2'b00;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
